// File: rtl/video_timing_gen_pkg.sv
// Shared widths, timing defaults, horizontal states and bar colours
// for the video timing generator.
package video_timing_pkg;

    localparam int HW = 12;
    localparam int VW = 11;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_HFP,
        ST_HSYNC,
        ST_HBP
    } hstate_t;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

    // Element 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic int h_total(input int a, input int fp,
                                   input int s, input int bp);
        return a + fp + s + bp;
    endfunction

    function automatic int v_total(input int a, input int fp,
                                   input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output bundle: resync input plus timing, coordinates and strobes.
// rgb exists only when VTG_TEST_PATTERN_EN is defined.
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic          vreset;
    logic          hs;
    logic          vs;
    logic          de;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          sof;
    logic          eol;
    logic [7:0]    resync_cnt;
`ifdef VTG_TEST_PATTERN_EN
    logic [23:0]   rgb;

    modport master (
        input  vreset,
        output hs, vs, de, x, y, sof, eol, resync_cnt, rgb
    );
    modport slave (
        output vreset,
        input  hs, vs, de, x, y, sof, eol, resync_cnt, rgb
    );
`else
    modport master (
        input  vreset,
        output hs, vs, de, x, y, sof, eol, resync_cnt
    );
    modport slave (
        output vreset,
        input  hs, vs, de, x, y, sof, eol, resync_cnt
    );
`endif

endinterface

// File: rtl/vtg_pattern.sv
// Colour-bar test pattern with a 1-pixel white border, registered so rgb
// lines up with de. Only built when VTG_TEST_PATTERN_EN is defined.
`ifdef VTG_TEST_PATTERN_EN
module vtg_pattern
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [HW-1:0] hcnt,
    input  logic [VW-1:0] vcnt,
    output logic [23:0]   rgb
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [HW-1:0] HA      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HA_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] VA      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);

    logic [23:0]   rgb_d;
    logic [23:0]   rgb_q;
    logic [HW-1:0] bar;
    logic [2:0]    idx;
    logic          act;
    logic          border;

    always_comb begin
        bar    = hcnt / HW'(BAR_W);
        // Clamp so a width not divisible by 8 widens the last bar.
        idx    = (bar > HW'(7)) ? 3'd7 : bar[2:0];
        act    = (hcnt < HA) && (vcnt < VA);
        border = (hcnt == '0) || (hcnt == HA_LAST) ||
                 (vcnt == '0) || (vcnt == VA_LAST);
        rgb_d  = '0;
        if (act) begin
            rgb_d = border ? RGB_WHITE : BAR_RGB[idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule
`endif

// File: rtl/video_timing_gen.sv
// Free-running video timing generator with vreset resync to the top-left
// pixel. Define VTG_TEST_PATTERN_EN to add the rgb colour-bar pattern.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic               clk,
    input  logic               resetn,
    video_timing_gen_if.master bus
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_A_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_FP_LAST = HW'(H_ACTIVE + H_FP - 1);
    localparam logic [HW-1:0] H_SY_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_A       = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SY_LO   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SY_HI   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
    localparam logic          HS_ON     = (HS_POL != 0);
    localparam logic          VS_ON     = (VS_POL != 0);

    logic [HW-1:0] hcnt_d, hcnt_q;
    logic [VW-1:0] vcnt_d, vcnt_q;
    logic [7:0]    rcnt_d, rcnt_q;
    hstate_t       state_d, state_q;

    logic          hs_d, hs_q;
    logic          vs_d, vs_q;
    logic          de_d, de_q;
    logic [HW-1:0] x_d, x_q;
    logic [VW-1:0] y_d, y_q;
    logic          sof_d, sof_q;
    logic          eol_d, eol_q;

    logic          h_act;
    logic          h_sync;
    logic          in_act;

    // Counters: vreset overrides the normal increment.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        rcnt_d = rcnt_q;
        if (bus.vreset) begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (rcnt_q != 8'hFF) begin
                rcnt_d = rcnt_q + 8'd1;
            end
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Horizontal region FSM tracks hcnt_q.
    always_comb begin
        state_d = state_q;
        if (bus.vreset) begin
            state_d = ST_ACTIVE;
        end else begin
            unique case (state_q)
                ST_ACTIVE: if (hcnt_q == H_A_LAST)  state_d = ST_HFP;
                ST_HFP:    if (hcnt_q == H_FP_LAST) state_d = ST_HSYNC;
                ST_HSYNC:  if (hcnt_q == H_SY_LAST) state_d = ST_HBP;
                ST_HBP:    if (hcnt_q == H_LAST)    state_d = ST_ACTIVE;
                default:   state_d = ST_ACTIVE;
            endcase
        end
    end

    always_comb begin
        h_act  = 1'b0;
        h_sync = 1'b0;
        unique case (1'b1)
            (state_q == ST_ACTIVE): h_act  = 1'b1;
            (state_q == ST_HSYNC):  h_sync = 1'b1;
            default: ;
        endcase
        in_act = h_act && (vcnt_q < V_A);
        de_d   = in_act;
        x_d    = in_act ? hcnt_q : '0;
        y_d    = in_act ? vcnt_q : '0;
        sof_d  = in_act && (hcnt_q == '0) && (vcnt_q == '0);
        eol_d  = in_act && (hcnt_q == H_A_LAST);
        hs_d   = h_sync ? HS_ON : !HS_ON;
        vs_d   = ((vcnt_q >= V_SY_LO) && (vcnt_q < V_SY_HI)) ? VS_ON : !VS_ON;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= ST_ACTIVE;
            hs_q    <= !HS_ON;
            vs_q    <= !VS_ON;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign bus.hs         = hs_q;
    assign bus.vs         = vs_q;
    assign bus.de         = de_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.sof        = sof_q;
    assign bus.eol        = eol_q;
    assign bus.resync_cnt = rcnt_q;

`ifdef VTG_TEST_PATTERN_EN
    logic [23:0] rgb;

    vtg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pattern (
        .clk    (clk),
        .resetn (resetn),
        .hcnt   (hcnt_q),
        .vcnt   (vcnt_q),
        .rgb    (rgb)
    );

    assign bus.rgb = rgb;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a shrunken timing set; outputs are
// compared every cycle against a linear frame-position model.
module tb_video_timing_gen;

    localparam int TH_A  = 32;
    localparam int TH_FP = 4;
    localparam int TH_SY = 6;
    localparam int TH_BP = 5;
    localparam int TV_A  = 8;
    localparam int TV_FP = 1;
    localparam int TV_SY = 3;
    localparam int TV_BP = 2;
    localparam int HT    = TH_A + TH_FP + TH_SY + TH_BP;
    localparam int VT    = TV_A + TV_FP + TV_SY + TV_BP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic [7:0]  rc;
`ifdef VTG_TEST_PATTERN_EN
        logic [23:0] rgb;
`endif
    } obs_t;

    typedef struct {
        int   h;
        int   v;
        logic hs_n;
        logic vs_n;
        logic de_n;
    } rs_vec_t;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } pat_vec_t;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;
    int   pos_m;
    int   rc_m;
    int   last_pos;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE (TH_A),
        .H_FP     (TH_FP),
        .H_SYNC   (TH_SY),
        .H_BP     (TH_BP),
        .V_ACTIVE (TV_A),
        .V_FP     (TV_FP),
        .V_SYNC   (TV_SY),
        .V_BP     (TV_BP),
        .HS_POL   (1),
        .VS_POL   (0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] bar_colour(input int i);
        logic [23:0] c [8];
        c = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return c[i];
    endfunction

    // Expected outputs one cycle after the counters sit at frame position p.
    function automatic obs_t ref_out(input int p, input int rc);
        obs_t o;
        int   h;
        int   v;
        logic act;
        h     = p % HT;
        v     = p / HT;
        act   = (h < TH_A) && (v < TV_A);
        o     = '0;
        o.hs  = (h >= TH_A + TH_FP) && (h < TH_A + TH_FP + TH_SY);
        o.vs  = !((v >= TV_A + TV_FP) && (v < TV_A + TV_FP + TV_SY));
        o.de  = act;
        o.x   = act ? 12'(h) : 12'd0;
        o.y   = act ? 11'(v) : 11'd0;
        o.sof = act && (p == 0);
        o.eol = act && (h == TH_A - 1);
        o.rc  = 8'(rc);
`ifdef VTG_TEST_PATTERN_EN
        if (!act) o.rgb = '0;
        else if (h == 0 || h == TH_A - 1 || v == 0 || v == TV_A - 1)
            o.rgb = 24'hFFFFFF;
        else
            o.rgb = bar_colour(h / (TH_A / 8));
`endif
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o    = '0;
        o.hs = 1'b0;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.hs  = vif.hs;
        o.vs  = vif.vs;
        o.de  = vif.de;
        o.x   = vif.x;
        o.y   = vif.y;
        o.sof = vif.sof;
        o.eol = vif.eol;
        o.rc  = vif.resync_cnt;
`ifdef VTG_TEST_PATTERN_EN
        o.rgb = vif.rgb;
`endif
        return o;
    endfunction

    task automatic check(input string nm, input obs_t e);
        obs_t a;
        a = get_obs();
        n_chk++;
        if (a !== e) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s t=%0t: got %h want %h", nm, $time, a, e);
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s t=%0t: got %0d want %0d", nm, $time, got, want);
        end
    endtask

    // One clock: drive vreset, advance the model at the edge, compare after.
    task automatic tick(input logic vr);
        obs_t e;
        vif.vreset = vr;
        @(posedge clk);
        if (vr) rc_m = (rc_m == 255) ? 255 : rc_m + 1;
        e        = ref_out(pos_m, rc_m);
        last_pos = pos_m;
        pos_m    = vr ? 0 : (pos_m + 1) % FRAME;
        @(negedge clk);
        check("stream", e);
    endtask

    task automatic goto_pos(input int target, input string nm);
        int n;
        n = 0;
        while (pos_m != target && n < 2 * FRAME) begin
            tick(1'b0);
            n++;
        end
        if (pos_m != target) check_val({nm, "_timeout"}, pos_m, target);
    endtask

    task automatic goto_obs(input int target, input string nm);
        int n;
        n = 0;
        while (last_pos != target && n < 2 * FRAME) begin
            tick(1'b0);
            n++;
        end
        if (last_pos != target) check_val({nm, "_timeout"}, last_pos, target);
    endtask

    initial begin
        rs_vec_t rs_tab [7];
        int de_n, hs_n, vs_n, sof_n, eol_n;
        int sof_t0, sof_per, fall_t, gap;
        logic de_p, hs_p;
`ifdef VTG_TEST_PATTERN_EN
        pat_vec_t pat_tab [8];
`endif

        rs_tab[0] = '{h: 20, v: 4,  hs_n: 1'b0, vs_n: 1'b1, de_n: 1'b1};
        rs_tab[1] = '{h: 38, v: 2,  hs_n: 1'b1, vs_n: 1'b1, de_n: 1'b0};
        rs_tab[2] = '{h: 46, v: 13, hs_n: 1'b0, vs_n: 1'b1, de_n: 1'b0};
        rs_tab[3] = '{h: 40, v: 10, hs_n: 1'b1, vs_n: 1'b0, de_n: 1'b0};
        rs_tab[4] = '{h: 0,  v: 0,  hs_n: 1'b0, vs_n: 1'b1, de_n: 1'b1};
        rs_tab[5] = '{h: 31, v: 7,  hs_n: 1'b0, vs_n: 1'b1, de_n: 1'b1};
        rs_tab[6] = '{h: 44, v: 9,  hs_n: 1'b0, vs_n: 1'b0, de_n: 1'b0};
`ifdef VTG_TEST_PATTERN_EN
        pat_tab[0] = '{x: 0,  y: 1, rgb: 24'hFFFFFF};
        pat_tab[1] = '{x: 5,  y: 1, rgb: 24'hFFFF00};
        pat_tab[2] = '{x: 30, y: 1, rgb: 24'h000000};
        pat_tab[3] = '{x: 31, y: 1, rgb: 24'hFFFFFF};
        pat_tab[4] = '{x: 10, y: 0, rgb: 24'hFFFFFF};
        pat_tab[5] = '{x: 10, y: 7, rgb: 24'hFFFFFF};
        pat_tab[6] = '{x: 40, y: 1, rgb: 24'h000000};
        pat_tab[7] = '{x: 10, y: 9, rgb: 24'h000000};
`endif

        n_chk      = 0;
        n_fail     = 0;
        pos_m      = 0;
        rc_m       = 0;
        last_pos   = -1;
        resetn     = 1'b0;
        vif.vreset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", reset_obs());
        resetn = 1'b1;

        // Two free-running frames.
        de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0; eol_n = 0;
        sof_t0 = -1; sof_per = -1; fall_t = -1; gap = -1;
        de_p = 1'b0; hs_p = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0);
            if (i < FRAME) begin
                de_n  += int'(vif.de);
                hs_n  += int'(vif.hs);
                vs_n  += int'(!vif.vs);
                sof_n += int'(vif.sof);
                eol_n += int'(vif.eol);
            end
            if (vif.sof) begin
                if (sof_t0 < 0) sof_t0 = i;
                else if (sof_per < 0) sof_per = i - sof_t0;
            end
            if (de_p && !vif.de && fall_t < 0) fall_t = i;
            if (!hs_p && vif.hs && fall_t >= 0 && gap < 0) gap = i - fall_t;
            de_p = vif.de;
            hs_p = vif.hs;
        end
        check_val("de_per_frame", de_n, TH_A * TV_A);
        check_val("hs_per_frame", hs_n, TH_SY * VT);
        check_val("vs_per_frame", vs_n, TV_SY * HT);
        check_val("sof_per_frame", sof_n, 1);
        check_val("eol_per_frame", eol_n, TV_A);
        check_val("sof_first", sof_t0, 0);
        check_val("frame_period", sof_per, FRAME);
        check_val("de_to_hs_gap", gap, TH_FP);

        // Resync at assorted counter positions.
        for (int i = 0; i < 7; i++) begin
            goto_pos(rs_tab[i].v * HT + rs_tab[i].h, "rs_goto");
            tick(1'b1);
            check_val("rs_pre_hs", int'(vif.hs), int'(rs_tab[i].hs_n));
            check_val("rs_pre_vs", int'(vif.vs), int'(rs_tab[i].vs_n));
            check_val("rs_pre_de", int'(vif.de), int'(rs_tab[i].de_n));
            tick(1'b0);
            check_val("rs_de", int'(vif.de), 1);
            check_val("rs_x", int'(vif.x), 0);
            check_val("rs_y", int'(vif.y), 0);
            check_val("rs_sof", int'(vif.sof), 1);
            check_val("rs_hs", int'(vif.hs), 0);
            check_val("rs_vs", int'(vif.vs), 1);
            check_val("rs_cnt", int'(vif.resync_cnt), i + 1);
            repeat (HT) tick(1'b0);
        end

        // Random resync traffic.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) == 0);
        end

        // Back-to-back pulses saturate the counter.
        repeat (300) tick(1'b1);
        check_val("rc_saturate", int'(vif.resync_cnt), 255);
        repeat (5) tick(1'b0);
        check_val("rc_hold", int'(vif.resync_cnt), 255);

`ifdef VTG_TEST_PATTERN_EN
        for (int i = 0; i < 8; i++) begin
            goto_obs(pat_tab[i].y * HT + pat_tab[i].x, "pat_goto");
            check_val("pattern_rgb", int'(vif.rgb), int'(pat_tab[i].rgb));
        end
`endif

        // Asynchronous reset in the middle of a line.
        goto_pos(2 * HT + 20, "rst_goto");
        #2 resetn = 1'b0;
        #1 check("async_reset", reset_obs());
        pos_m    = 0;
        rc_m     = 0;
        last_pos = -1;
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", reset_obs());
        resetn = 1'b1;
        tick(1'b0);
        check_val("post_reset_sof", int'(vif.sof), 1);
        check_val("post_reset_de", int'(vif.de), 1);
        repeat (HT * 2) tick(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
